// File: rtl/key_char_queue_if.sv
// Keystroke/character handshake bundle between the PS/2 decoder, the key queue and the scoring counter.
interface key_char_queue_if #(
   parameter int DEPTH = 8
);
   localparam int AW = $clog2(DEPTH);

   logic          enable;
   logic          flush;
   logic          key_valid;
   logic [7:0]    last_change;
   logic [127:0]  key_down;
   logic          char_valid;
   logic [4:0]    char_code;
   logic          char_ready;
   logic [AW:0]   level;
   logic          overflow;

   modport master (
      output enable, flush, key_valid, last_change, key_down, char_ready,
      input  char_valid, char_code, level, overflow
   );

   modport slave (
      input  enable, flush, key_valid, last_change, key_down, char_ready,
      output char_valid, char_code, level, overflow
   );
endinterface

// File: rtl/key_char_queue.sv
// PS/2 make events -> 5-bit character codes, buffered in a DEPTH-entry FIFO with valid/ready output.
// Optional typematic-repeat suppression enabled by defining KEYQ_REPEAT_FILTER_EN.
module key_char_queue #(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   key_char_queue_if.slave bus
);

   logic [4:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level_q;
   logic          overflow_q;

   logic [4:0]    code;
   logic          mapped;
   logic          is_down;
   logic          make_ev;
   logic          break_ev;
   logic          repeat_hit;
   logic          push_req;
   logic          push_ok;
   logic          pop;
   logic          full;
   logic          not_empty;

   always_comb begin
      code = '0;
      case (bus.last_change)
         8'h1C: code = 5'd1;
         8'h32: code = 5'd2;
         8'h21: code = 5'd3;
         8'h23: code = 5'd4;
         8'h24: code = 5'd5;
         8'h2B: code = 5'd6;
         8'h34: code = 5'd7;
         8'h33: code = 5'd8;
         8'h43: code = 5'd9;
         8'h3B: code = 5'd10;
         8'h42: code = 5'd11;
         8'h4B: code = 5'd12;
         8'h3A: code = 5'd13;
         8'h31: code = 5'd14;
         8'h44: code = 5'd15;
         8'h4D: code = 5'd16;
         8'h15: code = 5'd17;
         8'h2D: code = 5'd18;
         8'h1B: code = 5'd19;
         8'h2C: code = 5'd20;
         8'h3C: code = 5'd21;
         8'h2A: code = 5'd22;
         8'h1D: code = 5'd23;
         8'h22: code = 5'd24;
         8'h35: code = 5'd25;
         8'h1A: code = 5'd26;
         8'h29: code = 5'd27;
         8'h66: code = 5'd28;
         default: code = '0;
      endcase
   end

   // Scan codes above 7F have no key_down bit; treat them as released.
   assign is_down  = !bus.last_change[7] && bus.key_down[bus.last_change[6:0]];
   assign mapped   = (code != '0);
   assign make_ev  = bus.key_valid && is_down;
   assign break_ev = bus.key_valid && !is_down;

   assign not_empty = (level_q != '0);
   assign full      = (level_q == (AW+1)'(DEPTH));
   assign pop       = not_empty && bus.char_ready;
   assign push_req  = make_ev && mapped && bus.enable && !bus.flush && !repeat_hit;
   assign push_ok   = push_req && (!full || pop);

`ifdef KEYQ_REPEAT_FILTER_EN
   logic [4:0] last_code;

   assign repeat_hit = (code == last_code);

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         last_code <= '0;
      end else if (push_ok) begin
         last_code <= code;
      end else if (break_ev && mapped && code == last_code) begin
         last_code <= '0;
      end
   end
`else
   assign repeat_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= code;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop})
            2'b10:   level_q <= level_q + (AW+1)'(1);
            2'b01:   level_q <= level_q - (AW+1)'(1);
            default: level_q <= level_q;
         endcase
         if (push_req && !push_ok) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign bus.char_valid = not_empty;
   assign bus.char_code  = not_empty ? mem[rd_ptr] : '0;
   assign bus.level      = level_q;
   assign bus.overflow   = overflow_q;

endmodule
